// File: rtl/aes256_key_schedule_ctrl_pkg.sv
// Shared widths, FSM state type and AES constants for the iterative AES-256 key schedule.
// The S-box is stored as a constant table, with entry 0 in the most significant byte.
package aes256_key_schedule_ctrl_pkg;

  localparam int AES_WORD_W            = 32;
  localparam int AES_BLOCK_W           = 128;
  localparam int AES_KEY_W             = 256;
  localparam int AES_ROUND_W           = 4;
  localparam int AES256_NUM_ROUND_KEYS = 15;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_READY  = 2'd2
  } aes_ks_state_t;

  localparam logic [2047:0] AES_SBOX_TABLE = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  function automatic logic [7:0] aes_sbox_lookup(input logic [7:0] b);
    return AES_SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

  // Round constant for the byte in bits [7:0]; index is the even round divided by two.
  function automatic logic [7:0] aes_rcon(input logic [2:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    case (idx)
      3'd1:    rc = 8'h01;
      3'd2:    rc = 8'h02;
      3'd3:    rc = 8'h04;
      3'd4:    rc = 8'h08;
      3'd5:    rc = 8'h10;
      3'd6:    rc = 8'h20;
      3'd7:    rc = 8'h40;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes256_key_schedule_ctrl_key_step.sv
// One AES-256 key-expansion step: four new words from the last eight, selected by round parity.
// Bytes are little-endian within each word, so RotWord is a right-rotate by 8.
module aes_sbox
  import aes256_key_schedule_ctrl_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = aes_sbox_lookup(i_byte);

endmodule

module aes256_key_step
  import aes256_key_schedule_ctrl_pkg::*;
(
  input  logic [AES_KEY_W-1:0]   i_window,
  input  logic [AES_ROUND_W-1:0] i_round,
  output logic [AES_BLOCK_W-1:0] o_next_key
);

  logic [AES_WORD_W-1:0] w_last;
  logic [AES_WORD_W-1:0] w_rot;
  logic [AES_WORD_W-1:0] w_sub_in;
  logic [AES_WORD_W-1:0] w_sub;
  logic [AES_WORD_W-1:0] w_rcon_word;
  logic [AES_WORD_W-1:0] w_temp;
  logic [AES_WORD_W-1:0] w_next [4];

  assign w_last   = i_window[AES_KEY_W-1 -: AES_WORD_W];
  assign w_rot    = {w_last[7:0], w_last[AES_WORD_W-1:8]};
  // Odd rounds skip RotWord and Rcon.
  assign w_sub_in = i_round[0] ? w_last : w_rot;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_sub_in[8*gi +: 8]),
      .o_byte (w_sub[8*gi +: 8])
    );
  end

  assign w_rcon_word = i_round[0] ? '0 : {24'd0, aes_rcon(i_round[3:1])};
  assign w_temp      = w_sub ^ w_rcon_word;
  assign w_next[0]   = i_window[AES_WORD_W-1:0] ^ w_temp;

  for (gi = 1; gi < 4; gi++) begin : g_chain
    assign w_next[gi] = i_window[AES_WORD_W*gi +: AES_WORD_W] ^ w_next[gi-1];
  end

  assign o_next_key = {w_next[3], w_next[2], w_next[1], w_next[0]};

endmodule

// File: rtl/aes256_key_schedule_ctrl.sv
// Iterative AES-256 key-schedule controller: one expansion step per clock into a 15-entry
// round-key register file, read through a registered port by the cipher round engine.
module aes256_key_schedule_ctrl
  import aes256_key_schedule_ctrl_pkg::*;
#(
  parameter int NUM_ROUND_KEYS = AES256_NUM_ROUND_KEYS
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Key_valid,
  output logic                   Key_ready,
  input  logic [AES_KEY_W-1:0]   Input_key,
  output logic                   Busy,
  output logic                   Keys_valid,
  output logic                   Done,
  input  logic [AES_ROUND_W-1:0] Rk_addr,
  output logic [AES_BLOCK_W-1:0] Rk_data
);

  localparam logic [AES_ROUND_W-1:0] FIRST_ROUND = AES_ROUND_W'(2);
  localparam logic [AES_ROUND_W-1:0] LAST_ROUND  = AES_ROUND_W'(NUM_ROUND_KEYS - 1);

  aes_ks_state_t          r_state;
  logic [AES_ROUND_W-1:0] r_round;
  logic                   r_key_ready;
  logic                   r_busy;
  logic                   r_keys_valid;
  logic                   r_done;
  logic [AES_KEY_W-1:0]   r_window;
  logic [AES_BLOCK_W-1:0] r_rk [NUM_ROUND_KEYS];
  logic [AES_BLOCK_W-1:0] r_rk_data;

  logic                      w_accept;
  logic                      w_expand;
  logic [AES_BLOCK_W-1:0]    w_next_key;
  logic [NUM_ROUND_KEYS-1:0] w_wr_en;
  logic [AES_BLOCK_W-1:0]    w_wr_data [NUM_ROUND_KEYS];

  // Reset must block both key acceptance and expansion writes into the unreset storage.
  assign w_accept = Key_valid && r_key_ready && !Rst;
  assign w_expand = (r_state == KS_EXPAND) && !Rst;

  aes256_key_step u_step (
    .i_window   (r_window),
    .i_round    (r_round),
    .o_next_key (w_next_key)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= KS_IDLE;
      r_round      <= '0;
      r_key_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_keys_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        KS_IDLE, KS_READY: begin
          if (Key_valid) begin
            r_state      <= KS_EXPAND;
            r_round      <= FIRST_ROUND;
            r_key_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
          end
        end
        KS_EXPAND: begin
          if (r_round == LAST_ROUND) begin
            r_state      <= KS_READY;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b1;
            r_done       <= 1'b1;
          end else begin
            r_round <= r_round + AES_ROUND_W'(1);
          end
        end
        default: begin
          r_state     <= KS_IDLE;
          r_key_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_window <= Input_key;
    end else if (w_expand) begin
      r_window <= {w_next_key, r_window[AES_KEY_W-1:AES_BLOCK_W]};
    end
  end

  // Entries 0 and 1 come straight from the key; the rest from the step at their round.
  genvar gi;
  for (gi = 0; gi < NUM_ROUND_KEYS; gi++) begin : g_rk_wr
    if (gi == 0) begin : g_low
      assign w_wr_en[gi]   = w_accept;
      assign w_wr_data[gi] = Input_key[AES_BLOCK_W-1:0];
    end else if (gi == 1) begin : g_high
      assign w_wr_en[gi]   = w_accept;
      assign w_wr_data[gi] = Input_key[AES_KEY_W-1:AES_BLOCK_W];
    end else begin : g_step
      assign w_wr_en[gi]   = w_expand && (r_round == AES_ROUND_W'(gi));
      assign w_wr_data[gi] = w_next_key;
    end
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < NUM_ROUND_KEYS; i++) begin
      if (w_wr_en[i]) begin
        r_rk[i] <= w_wr_data[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rk_data <= '0;
    end else if (Rk_addr <= LAST_ROUND) begin
      r_rk_data <= r_rk[Rk_addr];
    end else begin
      r_rk_data <= '0;
    end
  end

  assign Key_ready  = r_key_ready;
  assign Busy       = r_busy;
  assign Keys_valid = r_keys_valid;
  assign Done       = r_done;
  assign Rk_data    = r_rk_data;

endmodule

// File: tb/tb_aes256_key_schedule_ctrl.sv
// Self-checking bench for aes256_key_schedule_ctrl against an independent key-schedule model
// whose S-box is derived from GF(2^8) inversion plus the affine transform.
module tb_aes256_key_schedule_ctrl;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Key_valid;
  logic         Key_ready;
  logic [255:0] Input_key;
  logic         Busy;
  logic         Keys_valid;
  logic         Done;
  logic [3:0]   Rk_addr;
  logic [127:0] Rk_data;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] model_rk [15];
  logic [127:0] exp_q [$];

  aes256_key_schedule_ctrl dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Key_valid  (Key_valid),
    .Key_ready  (Key_ready),
    .Input_key  (Input_key),
    .Busy       (Busy),
    .Keys_valid (Keys_valid),
    .Done       (Done),
    .Rk_addr    (Rk_addr),
    .Rk_data    (Rk_data)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        end
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_tab[w[8*b +: 8]];
    return r;
  endfunction

  task automatic model_expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0) begin
        temp = sub_word({temp[7:0], temp[31:8]}) ^ {24'd0, rc};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-8] ^ temp;
    end
    for (int k = 0; k < 15; k++) model_rk[k] = {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic read_one(input logic [3:0] addr, input logic [127:0] exp, input string tag);
    logic [127:0] want;
    Rk_addr = addr;
    exp_q.push_back(exp);
    tick();
    want = exp_q.pop_front();
    n_checks++;
    if (Rk_data !== want) begin
      n_fails++;
      $display("FAIL %s rd[%0d]: got %h want %h", tag, addr, Rk_data, want);
    end
  endtask

  task automatic read_burst(input string tag);
    logic [127:0] want;
    for (int a = 0; a < 16; a++) begin
      Rk_addr = 4'(a);
      exp_q.push_back((a < 15) ? model_rk[a] : 128'd0);
      tick();
      want = exp_q.pop_front();
      n_checks++;
      if (Rk_data !== want) begin
        n_fails++;
        $display("FAIL %s burst[%0d]: got %h want %h", tag, a, Rk_data, want);
      end
    end
  endtask

  // Accepts a key at the current cycle T and follows it cycle by cycle to T+14.
  task automatic run_key(input logic [255:0] key, input bit hold_valid, input int abort_at,
                         input bit rw_check, input string tag);
    logic [127:0] prev5;
    logic [127:0] want;
    bit exp_busy;
    bit exp_end;
    prev5 = model_rk[5];
    $display("key %s: %h", tag, key);
    n_checks++;
    if (Key_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL %s ready_at_accept: got %b want 1", tag, Key_ready);
    end
    Key_valid = 1'b1;
    Input_key = key;
    if (abort_at == 0) model_expand(key);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (abort_at != 0 && k == abort_at + 1) begin
        Rst = 1'b0;
        n_checks++;
        if (Busy !== 1'b0 || Key_ready !== 1'b1 || Keys_valid !== 1'b0 || Done !== 1'b0) begin
          n_fails++;
          $display("FAIL %s abort_state: got busy=%b ready=%b kv=%b done=%b want 0 1 0 0",
                   tag, Busy, Key_ready, Keys_valid, Done);
        end
        for (int j = 0; j < 4; j++) begin
          tick();
          n_checks++;
          if (Done !== 1'b0 || Keys_valid !== 1'b0 || Busy !== 1'b0) begin
            n_fails++;
            $display("FAIL %s post_abort[%0d]: got done=%b kv=%b busy=%b want 0 0 0",
                     tag, j, Done, Keys_valid, Busy);
          end
        end
        return;
      end
      if ((k == 1 && !hold_valid) || k == 13) Key_valid = 1'b0;
      exp_busy = (k <= 13);
      exp_end  = (k == 14);
      n_checks++;
      if (Busy !== exp_busy) begin
        n_fails++;
        $display("FAIL %s busy@T+%0d: got %b want %b", tag, k, Busy, exp_busy);
      end
      n_checks++;
      if (Key_ready !== exp_end) begin
        n_fails++;
        $display("FAIL %s ready@T+%0d: got %b want %b", tag, k, Key_ready, exp_end);
      end
      n_checks++;
      if (Done !== exp_end) begin
        n_fails++;
        $display("FAIL %s done@T+%0d: got %b want %b", tag, k, Done, exp_end);
      end
      n_checks++;
      if (Keys_valid !== exp_end) begin
        n_fails++;
        $display("FAIL %s keys_valid@T+%0d: got %b want %b", tag, k, Keys_valid, exp_end);
      end
      if (abort_at != 0 && k == abort_at) Rst = 1'b1;
      if (rw_check) begin
        if (k == 5 || k == 6) begin
          want = exp_q.pop_front();
          n_checks++;
          if (Rk_data !== want) begin
            n_fails++;
            $display("FAIL %s rk5_read@T+%0d: got %h want %h", tag, k - 1, Rk_data, want);
          end
        end
        if (k == 4) begin
          Rk_addr = 4'd5;
          exp_q.push_back(prev5);
        end else if (k == 5) begin
          Rk_addr = 4'd5;
          exp_q.push_back(model_rk[5]);
        end
      end
    end
  endtask

  task automatic test_reset();
    Rst       = 1'b1;
    Key_valid = 1'b1;
    Input_key = {8{32'hdeadbeef}};
    Rk_addr   = 4'd0;
    tick();
    tick();
    n_checks++;
    if (Key_ready !== 1'b1 || Busy !== 1'b0 || Keys_valid !== 1'b0 || Done !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b kv=%b done=%b want 1 0 0 0",
               Key_ready, Busy, Keys_valid, Done);
    end
    n_checks++;
    if (Rk_data !== 128'd0) begin
      n_fails++;
      $display("FAIL reset_rk_data: got %h want 0", Rk_data);
    end
    Rst       = 1'b0;
    Key_valid = 1'b0;
    tick();
    n_checks++;
    if (Busy !== 1'b0 || Key_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_wins_over_key: got busy=%b ready=%b want 0 1", Busy, Key_ready);
    end
  endtask

  task automatic test_fips_vectors();
    logic [255:0] key;
    for (int b = 0; b < 32; b++) key[8*b +: 8] = 8'(b);
    run_key(key, 1'b0, 0, 1'b0, "fips");
    read_one(4'd2,  128'h9cc072a593ce7fa998c476a19fc273a5, "fips_rk2");
    read_one(4'd14, 128'h36de686d3cc21a37e97909bfcc79fc24, "fips_rk14");
    read_one(4'd1,  128'h1f1e1d1c1b1a19181716151413121110, "fips_rk1");
    read_burst("fips");
  endtask

  task automatic test_back_to_back();
    logic [255:0] key;
    for (int b = 0; b < 32; b++) key[8*b +: 8] = 8'(b);
    run_key(key, 1'b1, 0, 1'b0, "held_valid");
    run_key(256'd0, 1'b0, 0, 1'b1, "b2b_zero");
    read_burst("b2b_zero");
  endtask

  task automatic test_reset_mid_expand();
    logic [255:0] key;
    for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
    run_key(key, 1'b0, 6, 1'b0, "abort");
    for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
    run_key(key, 1'b0, 0, 1'b0, "after_abort");
    read_burst("after_abort");
  endtask

  task automatic test_read_port();
    read_one(4'd15, 128'd0, "addr15");
    read_one(4'd0, model_rk[0], "addr0");
  endtask

  task automatic test_random_keys();
    logic [255:0] key;
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
      run_key(key, 1'b0, 0, 1'b0, "random");
      read_burst("random");
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_vectors();
    test_back_to_back();
    test_reset_mid_expand();
    test_read_port();
    test_random_keys();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
